// File: rtl/pipe_mem_pkg.sv
// Shared types and helpers for the pipelined data-memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipe_mem_pkg;

  localparam int WORD_W = 32;

  // Access sequencing: IDLE accepts requests, BUSY burns wait states.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Word-index width for a DEPTH-word array (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x 32 storage: combinational read port, write port committed at the rising edge.
// Latency: read 0 cycles, write visible after the closing edge.
// Backpressure: none; the controller decides when to write.
module mem_array
  import pipe_mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_wdat,
  output logic [WORD_W-1:0] o_rdat
);

  // Contents survive reset on purpose; the array has no reset network.
  logic [WORD_W-1:0] r_mem [DEPTH];

  // Single shared index: the access in flight reads and writes the same word.
  assign o_rdat = r_mem[i_idx];

  // Commit a store at the edge that closes the completing cycle.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdat;
    end
  end

endmodule

// File: rtl/pipeline_data_mem.sv
// Data-memory responder for the M stage: word read/write with WAIT_STATES programmable stall cycles.
// Latency: access completes WAIT_STATES cycles after the request cycle (same cycle when 0).
// Backpressure: MemStallM holds the pipeline; strobes must stay stable, dropping them aborts the access.
module pipeline_data_mem
  import pipe_mem_pkg::*;
#(
  parameter int DEPTH           = 64,
  parameter int WAIT_STATES     = 2,
  parameter int ERR_ON_MISALIGN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [WORD_W-1:0] ALUResultM,
  input  logic [WORD_W-1:0] WriteDataM,
  output logic [WORD_W-1:0] ReadDataM,
  output logic              MemStallM,
  output logic              MemDoneM,
  output logic              MemErrM
);

  localparam int IDX_W = idx_width(DEPTH);
  // The counter only ever holds WAIT_STATES-1 down to 0.
  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
      (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

  mem_state_t        r_state;
  mem_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              w_req;
  logic              w_misalign;
  logic              w_reject;
  logic              w_complete;
  logic              w_we;
  logic              w_stall;
  logic              w_done;
  logic              w_err;
  logic [IDX_W-1:0]  w_idx;
  logic [WORD_W-1:0] w_arr_rdat;
  logic [WORD_W-1:0] w_rdat;
  logic              w_unused;

  // Request decode; upper address bits are dropped so addresses wrap modulo DEPTH words.
  assign w_req      = MemReadM | MemWriteM;
  assign w_misalign = (ERR_ON_MISALIGN != 0) && (ALUResultM[1:0] != 2'b00);
  assign w_reject   = w_req && ((MemReadM && MemWriteM) || w_misalign);
  assign w_idx      = ALUResultM[IDX_W+1:2];
  assign w_unused   = ^ALUResultM[WORD_W-1:IDX_W+2];

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_idx  (w_idx),
    .i_wdat (WriteDataM),
    .o_rdat (w_arr_rdat)
  );

  // State and wait counter; reset drops any access in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state, counter and combinational outputs; strobes seen in the completing cycle are used.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_err       = 1'b0;
    w_complete  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_reject) begin
            w_err = 1'b1;
          end else if (WAIT_STATES == 0) begin
            w_complete = 1'b1;
          end else begin
            // Stall is raised in the request cycle itself so the pipeline freezes immediately.
            w_stall     = 1'b1;
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (!w_req) begin
          // Datapath withdrew the request: abandon without touching the array.
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else if (r_cnt != '0) begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else if (w_reject) begin
          // Strobes turned illegal by completion time: reject instead of accessing.
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase

    w_done = w_complete;
    w_we   = w_complete && MemWriteM;
    w_rdat = (w_complete && MemReadM) ? w_arr_rdat : '0;

    // While reset is held everything is quiet even if strobes are still asserted.
    if (!reset) begin
      w_stall = 1'b0;
      w_err   = 1'b0;
      w_done  = 1'b0;
      w_we    = 1'b0;
      w_rdat  = '0;
    end
  end

  assign MemStallM = w_stall;
  assign MemDoneM  = w_done;
  assign MemErrM   = w_err;
  assign ReadDataM = w_rdat;

endmodule

// File: tb/tb_pipeline_data_mem.sv
module tb_pipeline_data_mem;

  logic        clk;
  logic        reset;
  logic        rd    [3];
  logic        wr    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdat  [3];
  logic [31:0] rdat  [3];
  logic        stall [3];
  logic        done  [3];
  logic        err   [3];

  int checks = 0;
  int errors = 0;

  // Instance k has WAIT_STATES ws_of[k]; all use DEPTH=64 and misalign checking.
  int ws_of [3] = '{0, 2, 3};

  // Reference memory: plain word array per instance, updated when a write completes.
  logic [31:0] model [3][64];

  pipeline_data_mem #(.DEPTH(64), .WAIT_STATES(0), .ERR_ON_MISALIGN(1)) u_ws0 (
    .clk(clk), .reset(reset), .MemReadM(rd[0]), .MemWriteM(wr[0]),
    .ALUResultM(addr[0]), .WriteDataM(wdat[0]), .ReadDataM(rdat[0]),
    .MemStallM(stall[0]), .MemDoneM(done[0]), .MemErrM(err[0]));

  pipeline_data_mem #(.DEPTH(64), .WAIT_STATES(2), .ERR_ON_MISALIGN(1)) u_ws2 (
    .clk(clk), .reset(reset), .MemReadM(rd[1]), .MemWriteM(wr[1]),
    .ALUResultM(addr[1]), .WriteDataM(wdat[1]), .ReadDataM(rdat[1]),
    .MemStallM(stall[1]), .MemDoneM(done[1]), .MemErrM(err[1]));

  pipeline_data_mem #(.DEPTH(64), .WAIT_STATES(3), .ERR_ON_MISALIGN(1)) u_ws3 (
    .clk(clk), .reset(reset), .MemReadM(rd[2]), .MemWriteM(wr[2]),
    .ALUResultM(addr[2]), .WriteDataM(wdat[2]), .ReadDataM(rdat[2]),
    .MemStallM(stall[2]), .MemDoneM(done[2]), .MemErrM(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request, held until it completes; checks every cycle against the transaction rules.
  task automatic access(input int k, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    bit          req;
    bit          rej;
    bit          e_st;
    bit          e_dn;
    int          n;
    int          ix;
    logic [31:0] e_rd;
    req = r | w;
    rej = req && ((r && w) || (a[1:0] != 2'b00));
    ix  = int'(a[7:2]);
    n   = (req && !rej) ? ws_of[k] : 0;
    rd[k] = r; wr[k] = w; addr[k] = a; wdat[k] = d;
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      e_st = req && !rej && (c < n);
      e_dn = req && !rej && (c == n);
      e_rd = (e_dn && r) ? model[k][ix] : 32'h0;
      checks += 4;
      if (stall[k] !== e_st) begin
        errors++;
        $display("FAIL %s k=%0d cyc=%0d stall got %b exp %b", tag, k, c, stall[k], e_st);
      end
      if (done[k] !== e_dn) begin
        errors++;
        $display("FAIL %s k=%0d cyc=%0d done got %b exp %b", tag, k, c, done[k], e_dn);
      end
      if (err[k] !== rej) begin
        errors++;
        $display("FAIL %s k=%0d cyc=%0d err got %b exp %b", tag, k, c, err[k], rej);
      end
      if (rdat[k] !== e_rd) begin
        errors++;
        $display("FAIL %s k=%0d cyc=%0d rdata got %h exp %h", tag, k, c, rdat[k], e_rd);
      end
      @(posedge clk);
      if (e_dn && w) model[k][ix] = d;
      #1;
    end
  endtask

  // Strobes low for n cycles: every output must be quiet.
  task automatic idle(input int k, input int n);
    rd[k] = 1'b0; wr[k] = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      checks++;
      if ({stall[k], done[k], err[k], rdat[k]} !== 35'h0) begin
        errors++;
        $display("FAIL idle k=%0d stall %b done %b err %b rdata %h exp all 0",
                 k, stall[k], done[k], err[k], rdat[k]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdat[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({stall[k], done[k], err[k], rdat[k]} !== 35'h0) begin
        errors++;
        $display("FAIL reset k=%0d outputs stall %b done %b err %b rdata %h exp all 0",
                 k, stall[k], done[k], err[k], rdat[k]);
      end
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Give every word a known value so all later reads have a defined expectation.
  task automatic test_preload();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 64; i++)
        access(k, 1'b0, 1'b1, 32'(i * 4), $urandom, "preload");
    for (int k = 0; k < 3; k++) idle(k, 1);
  endtask

  task automatic test_ws0_basic();
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "ws0_write");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, "ws0_read");
    checks++;
    if (model[0][4] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ws0_model got %h exp %h", model[0][4], 32'hDEADBEEF);
    end
    idle(0, 1);
  endtask

  task automatic test_ws2_read();
    access(1, 1'b0, 1'b1, 32'h20, 32'h12345678, "ws2_preload");
    idle(1, 1);
    access(1, 1'b1, 1'b0, 32'h20, 32'h0, "ws2_read");
    idle(1, 1);
  endtask

  task automatic test_errors();
    for (int k = 0; k < 3; k++) begin
      access(k, 1'b0, 1'b1, 32'h22, 32'hFFFF0000, "misalign_write");
      access(k, 1'b1, 1'b1, 32'h24, 32'h0BADF00D, "both_strobes");
      access(k, 1'b1, 1'b0, 32'h20, 32'h0, "err_read20");
      access(k, 1'b1, 1'b0, 32'h24, 32'h0, "err_read24");
      idle(k, 1);
    end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 2; k++) begin
      access(k, 1'b0, 1'b1, 32'h100, 32'hA5A5A5A5, "wrap_write");
      access(k, 1'b1, 1'b0, 32'h000, 32'h0, "wrap_read");
      checks++;
      if (model[k][0] !== 32'hA5A5A5A5) begin
        errors++;
        $display("FAIL wrap_model k=%0d got %h exp %h", k, model[k][0], 32'hA5A5A5A5);
      end
      idle(k, 1);
    end
  endtask

  // Withdraw a write after one stall cycle on the 3-wait-state instance.
  task automatic test_abort();
    rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 32'h8; wdat[2] = 32'h55;
    @(negedge clk);
    checks++;
    if (stall[2] !== 1'b1 || done[2] !== 1'b0) begin
      errors++;
      $display("FAIL abort_req stall %b done %b exp 1 0", stall[2], done[2]);
    end
    @(posedge clk);
    #1;
    wr[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (done[2] !== 1'b0 || err[2] !== 1'b0 || rdat[2] !== 32'h0) begin
      errors++;
      $display("FAIL abort_drop done %b err %b rdata %h exp 0 0 0", done[2], err[2], rdat[2]);
    end
    @(posedge clk);
    #1;
    idle(2, 2);
    access(2, 1'b1, 1'b0, 32'h8, 32'h0, "abort_read");
    idle(2, 1);
  endtask

  // Assert reset while a write is stalled; the write must be lost.
  task automatic test_reset_mid();
    rd[2] = 1'b0; wr[2] = 1'b1; addr[2] = 32'hC; wdat[2] = 32'hC0FFEE11;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({stall[2], done[2], err[2], rdat[2]} !== 35'h0) begin
      errors++;
      $display("FAIL reset_mid stall %b done %b err %b rdata %h exp all 0",
               stall[2], done[2], err[2], rdat[2]);
    end
    wr[2] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    access(2, 1'b1, 1'b0, 32'hC, 32'h0, "reset_mid_read");
    idle(2, 1);
  endtask

  // Random mix of reads, writes and illegal requests, mostly back-to-back.
  task automatic test_random();
    int          kind;
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 60; i++) begin
        kind = $urandom_range(0, 5);
        a    = $urandom & 32'hFFFF_FFFC;
        case (kind)
          0, 1: access(k, 1'b1, 1'b0, a, $urandom, "rand_read");
          2, 3: access(k, 1'b0, 1'b1, a, $urandom, "rand_write");
          4:    access(k, 1'b1, 1'b1, a, $urandom, "rand_both");
          default: access(k, $urandom_range(0, 1) == 1, 1'b1,
                          a | 32'($urandom_range(1, 3)), $urandom, "rand_misalign");
        endcase
        if ($urandom_range(0, 3) == 0) idle(k, 1);
      end
      idle(k, 1);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_ws0_basic();
    test_ws2_read();
    test_errors();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
